// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: drives a req/ack byte-lane bus,
// formats load results and stalls the pipeline until each access completes.
module mem_access_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        misaligned,
  output logic        bus_fault
);

  localparam logic [3:0] OP_LB  = 4'b1000;
  localparam logic [3:0] OP_LH  = 4'b1001;
  localparam logic [3:0] OP_LW  = 4'b1010;
  localparam logic [3:0] OP_LBU = 4'b1100;
  localparam logic [3:0] OP_LHU = 4'b1101;
  localparam logic [3:0] OP_SB  = 4'b0100;
  localparam logic [3:0] OP_SH  = 4'b0101;
  localparam logic [3:0] OP_SW  = 4'b0110;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_q;
  logic [1:0]       lane_q;
  logic             is_load, is_store, op_mis, issue, tmo_hit;

  function automatic logic [31:0] fmt_load(input logic [3:0] op, input logic [1:0] lane,
                                           input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = rdata[{lane, 3'b000} +: 8];
    h = rdata[{lane[1], 4'b0000} +: 16];
    case (op)
      OP_LB:   r = 32'(b);
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = 32'(h);
      OP_LHU:  r = {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] fmt_wdata(input logic [3:0] op, input logic [31:0] sdata);
    case (op)
      OP_SB:   return {4{sdata[7:0]}};
      OP_SH:   return {2{sdata[15:0]}};
      default: return sdata;
    endcase
  endfunction

  function automatic logic [3:0] fmt_wmask(input logic [3:0] op, input logic [1:0] lane);
    case (op)
      OP_SB:   return 4'b0001 << lane;
      OP_SH:   return lane[1] ? 4'b1100 : 4'b0011;
      OP_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Decode of the op presented by the EX/MEM register
  always_comb begin
    is_load  = (mem_op == OP_LB) || (mem_op == OP_LH) || (mem_op == OP_LW) ||
               (mem_op == OP_LBU) || (mem_op == OP_LHU);
    is_store = (mem_op == OP_SB) || (mem_op == OP_SH) || (mem_op == OP_SW);
    op_mis   = (((mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH)) && addr[0]) ||
               (((mem_op == OP_LW) || (mem_op == OP_SW)) && (addr[1:0] != 2'b00));
    misaligned = (state == IDLE) && op_mis;
    issue      = (state == IDLE) && (is_load || is_store) && !op_mis;
    tmo_hit    = (TIMEOUT != 0) && (cnt == TMO_LAST);
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        busy = issue;
        if (issue) state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (mem_ack || tmo_hit) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus fields are latched at issue so the access is immune to later input changes
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      load_data <= '0;
      bus_fault <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (issue) begin
          mem_req   <= 1'b1;
          mem_we    <= is_store;
          mem_addr  <= {addr[31:2], 2'b00};
          mem_wdata <= fmt_wdata(mem_op, store_data);
          mem_wmask <= fmt_wmask(mem_op, addr[1:0]);
          op_q      <= mem_op;
          lane_q    <= addr[1:0];
          cnt       <= '0;
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_ack) begin
            mem_req   <= 1'b0;
            bus_fault <= 1'b0;
            if (op_q[3]) load_data <= fmt_load(op_q, lane_q, mem_rdata);
          end else if (tmo_hit) begin
            mem_req   <= 1'b0;
            bus_fault <= 1'b1;
          end
        end
        RESP:    bus_fault <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
